// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, register count and requester index type
package regfile_wb_arbiter_pkg;
  localparam int DEF_REGISTER_LEN = 32;
  localparam int DEF_REGFILE_ADDRESS_LEN = 4;
  localparam int NUM_REGS = 16;
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_idx_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: issue, two write-back requesters, register-file write port, busy/overflow status
interface regfile_wb_arbiter_if #(
  parameter int REGISTER_LEN = regfile_wb_arbiter_pkg::DEF_REGISTER_LEN,
  parameter int REGFILE_ADDRESS_LEN = regfile_wb_arbiter_pkg::DEF_REGFILE_ADDRESS_LEN
);
  logic issue_valid;
  logic [REGFILE_ADDRESS_LEN-1:0] issue_dest;
  logic req0_valid, req0_ready;
  logic [REGFILE_ADDRESS_LEN-1:0] req0_dest;
  logic [REGISTER_LEN-1:0] req0_data;
  logic req1_valid, req1_ready;
  logic [REGFILE_ADDRESS_LEN-1:0] req1_dest;
  logic [REGISTER_LEN-1:0] req1_data;
  logic wb_enable;
  logic [REGFILE_ADDRESS_LEN-1:0] dest_wb;
  logic [REGISTER_LEN-1:0] result_wb;
  logic [regfile_wb_arbiter_pkg::NUM_REGS-1:0] busy;
  logic overflow;
  modport master (
    output issue_valid, issue_dest, req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data,
    input req0_ready, req1_ready, wb_enable, dest_wb, result_wb, busy, overflow
  );
  modport slave (
    input issue_valid, issue_dest, req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data,
    output req0_ready, req1_ready, wb_enable, dest_wb, result_wb, busy, overflow
  );
endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// wb_scoreboard: saturating 2-bit pending count per register; issue increments, accepted write-back decrements, busy/overflow out
module wb_scoreboard #(
  parameter int AW = regfile_wb_arbiter_pkg::DEF_REGFILE_ADDRESS_LEN,
  parameter int N = regfile_wb_arbiter_pkg::NUM_REGS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic [AW-1:0] inc_idx_i,
  input  logic dec_i,
  input  logic [AW-1:0] dec_idx_i,
  output logic [N-1:0] busy_o,
  output logic ovf_o
);
  logic [N-1:0] err;
  logic ovf_q, ovf_d;
  for (genvar i = 0; i < N; i++) begin : g_reg
    logic inc, dec;
    logic [1:0] cnt_q, cnt_d;
    assign inc = inc_i && inc_idx_i == AW'(i);
    assign dec = dec_i && dec_idx_i == AW'(i);
    assign cnt_d = (inc == dec) ? cnt_q
                 : inc ? ((cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1)
                 : ((cnt_q == 2'd0) ? cnt_q : cnt_q - 2'd1);
    assign err[i] = (inc && !dec && cnt_q == 2'd3) || (dec && !inc && cnt_q == 2'd0);
    assign busy_o[i] = |cnt_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= 2'd0;
      else cnt_q <= cnt_d;
  end
  assign ovf_d = ovf_q | (|err);
  assign ovf_o = ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of two write-back requesters onto one registered register-file write port, with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int REGISTER_LEN = regfile_wb_arbiter_pkg::DEF_REGISTER_LEN,
  parameter int REGFILE_ADDRESS_LEN = regfile_wb_arbiter_pkg::DEF_REGFILE_ADDRESS_LEN
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);
  import regfile_wb_arbiter_pkg::*;
  req_idx_t rr_q, rr_d;
  logic g0, g1, xfer;
  logic [REGFILE_ADDRESS_LEN-1:0] sel_dest, dest_q, dest_d;
  logic [REGISTER_LEN-1:0] sel_data, data_q, data_d;
  logic wbe_q, wbe_d;
  always_comb begin
    g0 = rst_n && bus.req0_valid && (!bus.req1_valid || rr_q == REQ1);
    g1 = rst_n && bus.req1_valid && (!bus.req0_valid || rr_q == REQ0);
    xfer = g0 || g1;
    sel_dest = g1 ? bus.req1_dest : bus.req0_dest;
    sel_data = g1 ? bus.req1_data : bus.req0_data;
    rr_d = xfer ? (g1 ? REQ1 : REQ0) : rr_q;
    wbe_d = xfer;
    dest_d = xfer ? sel_dest : dest_q;
    data_d = xfer ? sel_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_q <= REQ1;
      wbe_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      rr_q <= rr_d;
      wbe_q <= wbe_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.wb_enable = wbe_q;
  assign bus.dest_wb = dest_q;
  assign bus.result_wb = data_q;
  wb_scoreboard #(.AW(REGFILE_ADDRESS_LEN), .N(NUM_REGS)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .inc_i(bus.issue_valid),
    .inc_idx_i(bus.issue_dest),
    .dec_i(xfer),
    .dec_idx_i(sel_dest),
    .busy_o(bus.busy),
    .ovf_o(bus.overflow)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven vectors plus hand sequences, write-back scoreboard queue and behavioural pending model
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;
  localparam int RL = DEF_REGISTER_LEN;
  localparam int AW = DEF_REGFILE_ADDRESS_LEN;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic iv;
    logic [AW-1:0] idst;
    logic v0;
    logic [AW-1:0] d0;
    logic [RL-1:0] x0;
    logic v1;
    logic [AW-1:0] d1;
    logic [RL-1:0] x1;
    logic r0;
    logic r1;
  } vec_t;
  typedef struct {
    logic [AW-1:0] dest;
    logic [RL-1:0] data;
  } wb_t;
  wb_t exp_q[$];
  vec_t tbl[15];
  int passed = 0;
  int total = 0;
  int m_cnt[NUM_REGS];
  logic m_ovf;
  logic m_last1;

  function automatic vec_t mk(logic iv, logic [AW-1:0] idst, logic v0, logic [AW-1:0] d0, logic [RL-1:0] x0,
                              logic v1, logic [AW-1:0] d1, logic [RL-1:0] x1, logic r0, logic r1);
    vec_t v;
    v.iv = iv; v.idst = idst; v.v0 = v0; v.d0 = d0; v.x0 = x0;
    v.v1 = v1; v.d1 = d1; v.x1 = x1; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_busy();
    logic [NUM_REGS-1:0] b;
    for (int i = 0; i < NUM_REGS; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
    m_ovf = 1'b0;
    m_last1 = 1'b1;
    exp_q.delete();
  endtask

  task automatic m_edge(input logic iv, input logic [AW-1:0] idst, input logic dec, input logic [AW-1:0] dd);
    if (!(iv && dec && idst == dd)) begin
      if (iv) begin
        if (m_cnt[idst] == 3) m_ovf = 1'b1;
        else m_cnt[idst]++;
      end
      if (dec) begin
        if (m_cnt[dd] == 0) m_ovf = 1'b1;
        else m_cnt[dd]--;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    bus.issue_valid = v.iv; bus.issue_dest = v.idst;
    bus.req0_valid = v.v0; bus.req0_dest = v.d0; bus.req0_data = v.x0;
    bus.req1_valid = v.v1; bus.req1_dest = v.d1; bus.req1_data = v.x1;
  endtask

  task automatic step(input vec_t v);
    logic g0, g1;
    wb_t e;
    @(negedge clk);
    drive(v);
    #1;
    chk("req0_ready", bus.req0_ready, v.r0);
    chk("req1_ready", bus.req1_ready, v.r1);
    g0 = v.v0 && (!v.v1 || m_last1);
    g1 = v.v1 && (!v.v0 || !m_last1);
    e.dest = g1 ? v.d1 : v.d0;
    e.data = g1 ? v.x1 : v.x0;
    if (g0 || g1) begin
      exp_q.push_back(e);
      m_last1 = g1;
    end
    m_edge(v.iv, v.idst, g0 || g1, e.dest);
    @(posedge clk);
    #1;
    chk("wb_enable", bus.wb_enable, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("dest_wb", bus.dest_wb, e.dest);
      chk("result_wb", bus.result_wb, e.data);
    end
    chk("busy", bus.busy, m_busy());
    chk("overflow", bus.overflow, m_ovf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.issue_valid = 1'b0;
    m_reset();
    #1;
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_wb_enable", bus.wb_enable, 1'b0);
    chk("rst_dest_wb", bus.dest_wb, '0);
    chk("rst_result_wb", bus.result_wb, '0);
    chk("rst_busy", bus.busy, '0);
    chk("rst_overflow", bus.overflow, 1'b0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    m_reset();
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0);
    tbl[7]  = mk(0, 0, 1, 1, 32'h12, 1, 2, 32'h23, 0, 1);
    tbl[8]  = mk(0, 0, 1, 1, 32'h13, 1, 2, 32'h24, 1, 0);
    tbl[9]  = mk(0, 0, 1, 1, 32'h14, 1, 2, 32'h25, 0, 1);
    tbl[10] = mk(0, 0, 1, 3, 32'hA5, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 8, 0, 0, 0, 1, 6, 32'h66, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 1, 8, 32'h88, 0, 0, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 15; i++) step(tbl[i]);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    step(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("busy5_after_issue", bus.busy[5], 1'b1);
    step(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 1, 5, 32'h51, 0, 0, 0, 1, 0));
    chk("busy5_after_wb1", bus.busy[5], 1'b1);
    step(mk(0, 0, 0, 0, 0, 1, 5, 32'h52, 0, 1));
    chk("busy5_after_wb2", bus.busy[5], 1'b0);

    step(mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 7, 1, 7, 32'h71, 0, 0, 0, 1, 0));
    chk("busy7_same_edge", bus.busy[7], 1'b1);
    step(mk(0, 0, 0, 0, 0, 1, 7, 32'h72, 0, 1));
    chk("busy7_cleared", bus.busy[7], 1'b0);
    chk("no_ovf_count1", bus.overflow, 1'b0);

    do_reset();
    step(mk(0, 0, 1, 9, 32'h99, 0, 0, 0, 1, 0));
    chk("ovf_wb_zero", bus.overflow, 1'b1);
    chk("wb9_written", bus.dest_wb, 4'd9);

    do_reset();
    for (int i = 0; i < 4; i++) step(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("ovf_saturate", bus.overflow, 1'b1);
    for (int i = 0; i < 2; i++) step(mk(0, 0, 1, 4, 32'h40 + i, 0, 0, 0, 1, 0));
    chk("busy4_still_set", bus.busy[4], 1'b1);
    step(mk(0, 0, 1, 4, 32'h42, 0, 0, 0, 1, 0));
    chk("busy4_clear_at3", bus.busy[4], 1'b0);

    step(mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 1, 10, 32'hBEEF, 0, 0, 0, 1, 0));
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_dest = 4'd11; bus.req0_data = 32'hDEAD;
    #1;
    chk("mid_ready0", bus.req0_ready, 1'b1);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_wb_enable", bus.wb_enable, 1'b0);
    chk("mid_busy", bus.busy, '0);
    chk("mid_overflow", bus.overflow, 1'b0);
    chk("mid_ready0_low", bus.req0_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_no_pulse", bus.wb_enable, 1'b0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 1, 13, 32'hC0, 1, 14, 32'hC1, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter REGISTER_LEN, default 32: width of the write-back data.
REQ-002 The block SHALL have parameter REGFILE_ADDRESS_LEN, default 4: width of the register index; 16 registers.
REQ-003 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have ports issue_valid (input, 1) and issue_dest (input, REGFILE_ADDRESS_LEN): a decoded instruction will write issue_dest.
REQ-006 The block SHALL have ports req0_valid (input, 1), req0_dest (input, REGFILE_ADDRESS_LEN), req0_data (input, REGISTER_LEN) and req0_ready (output, 1): the ALU write-back requester.
REQ-007 The block SHALL have ports req1_valid, req1_dest, req1_data and req1_ready with the same directions and widths: the load write-back requester.
REQ-008 The block SHALL have ports wb_enable (output, 1), dest_wb (output, REGFILE_ADDRESS_LEN) and result_wb (output, REGISTER_LEN): the single register-file write port.
REQ-009 The block SHALL have port busy (output, 16): bit i set while register i has at least one outstanding write.
REQ-010 The block SHALL have port overflow (output, 1): a sticky error flag.

Function
REQ-011 A transfer on requester k SHALL occur when reqk_valid and reqk_ready are both high on a rising clk edge.
REQ-012 reqk_ready SHALL be a combinational function of both valids and the round-robin pointer only, with no path from the data or dest inputs.
REQ-013 If exactly one requester is valid, it SHALL be granted (ready high) that cycle.
REQ-014 If both requesters are valid, the requester not granted most recently SHALL be granted, and the other SHALL see ready low.
REQ-015 If neither requester is valid, both ready outputs SHALL be low.
REQ-016 The round-robin pointer SHALL record the last granted requester, SHALL update only on a transfer, and SHALL reset to favour req0.
REQ-017 The output stage SHALL be registered with 1-cycle latency: the edge that accepts a transfer loads wb_enable=1, dest_wb and result_wb.
REQ-018 In a cycle with no transfer, wb_enable SHALL be loaded with 0, and dest_wb and result_wb SHALL hold their values.
REQ-019 The output stage SHALL never stall: the register file accepts a write every cycle, so sustained throughput is one write per clock.
REQ-020 The block SHALL keep a 2-bit pending count per register.
REQ-021 An issue SHALL increment pending[issue_dest].
REQ-022 The accepted write-back SHALL decrement pending of the written register on the transfer edge, not the edge on which wb_enable is seen.
REQ-023 If an issue and a write-back to the same register occur on the same edge, that register's count SHALL be unchanged.
REQ-024 If an issue and a write-back to different registers occur on the same edge, both counts SHALL update independently.
REQ-025 An increment of a count already at 3 SHALL saturate at 3 and SHALL set overflow.
REQ-026 A write-back to a register whose count is 0 SHALL leave the count at 0, SHALL set overflow, and SHALL still be written to the register file.
REQ-027 overflow SHALL remain set until reset.
REQ-028 busy[i] SHALL equal (pending[i] != 0) and SHALL be driven from registered state.
REQ-029 Both requesters targeting the same dest in one cycle SHALL be legal; the two writes SHALL be serialized in grant order.

Reset
REQ-030 Assertion of rst_n low SHALL immediately clear wb_enable, dest_wb, result_wb, all pending counts, busy and overflow, and SHALL set the round-robin pointer to favour req0.
REQ-031 Reset mid-operation SHALL drop any in-flight write, so no write pulse appears after deassertion.
REQ-032 The block SHALL deassert both ready outputs while rst_n is low.

Structure
REQ-033 REGISTER_LEN, REGFILE_ADDRESS_LEN and the register count (16) SHALL come from the shared defines package.
REQ-034 The requester index SHALL be a 1-bit type in the same shared package.
REQ-035 The pending-count scoreboard SHALL be the single sub-module, named wb_scoreboard (inputs: issue and decrement strobes with their indices; outputs: busy and overflow).
REQ-036 The arbiter and the output register SHALL stay in the top module.

Verification
REQ-037 Scenario single requester: after reset, req0 valid with dest 3 and data 0xA5 for one cycle -> req0_ready=1 that cycle, and wb_enable=1, dest_wb=3, result_wb=0xA5 the next cycle, then wb_enable=0.
REQ-038 Scenario contention: both requesters valid continuously with dests 1 and 2 -> grants alternate req0, req1, req0, req1; the write port shows dests 1, 2, 1, 2 on consecutive cycles.
REQ-039 Scenario scoreboard: issue dest 5 twice, then two write-backs to 5 -> busy[5] rises after the first issue, stays set after the first write-back, and clears on the edge of the second transfer.
REQ-040 Scenario simultaneous events: pending[7]=1, then issue 7 and write-back 7 on the same edge -> busy[7] stays 1 and the count stays 1.
REQ-041 Scenario errors: a write-back to register 9 with count 0 -> overflow=1 and the write still occurs; four issues to register 4 -> overflow=1 and the count saturates at 3.
REQ-042 Scenario reset mid-operation: assert rst_n low while a transfer is accepted -> wb_enable=0, busy=0 and overflow=0 immediately, and the first grant after release goes to req0.
